mmio_port_responder: RTL and testbench
======================================

Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus (MemRead/MemWrite/Address/WriteData), sitting beside the data RAM in the MEM stage.
- Owns the external output port, a synchronized input port with change detection, and a 32-bit timer with compare match and interrupt request.
- The hit output lets the processor's MEM-stage read mux select this block's ReadData instead of RAM data.

Parameters:
- BASE_ADDR, 32'h1001_0400: register window base; must be 32-byte aligned.
- IN_WIDTH, 8: PortIn width; zero-extended into 32-bit reads.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- MemRead, input, 1: load strobe from the MEM stage.
- MemWrite, input, 1: store strobe from the MEM stage.
- Address, input, 32: byte address from the MEM-stage ALU result.
- WriteData, input, 32: store data.
- ReadData, output, 32: load data, combinational.
- hit, output, 1: access targets this block, combinational.
- PortIn, input, IN_WIDTH: asynchronous external input.
- PortOut, output, 32: external output port, registered.
- irq, output, 1: interrupt request, combinational from registers.

Behaviour:
- Decode: hit = (MemRead | MemWrite) & (Address[31:5] == BASE_ADDR[31:5]).
  - Register offset = Address[4:2]; Address[1:0] ignored.
  - Offsets 6 and 7 are unmapped: hit still 1, reads return 0, writes are ignored.
- Register map (word offset):
  - 0 PORT_OUT, RW.
  - 1 PORT_IN, RO.
  - 2 STATUS, W1C: bit0 in_changed, bit1 tmr_match.
  - 3 TMR_CNT, RW.
  - 4 TMR_CMP, RW.
  - 5 CTRL, RW: bit0 tmr_en, bit1 auto_clr, bit2 irq_in_en, bit3 irq_tmr_en; bits 31:4 read 0.
- Writes: take effect on the rising edge where MemWrite & hit. Writes to RO registers are ignored.
- Reads: ReadData = selected register when MemRead & hit, else 32'h0. Zero latency, so the pipeline captures it in the same cycle as RAM data.
- MemRead and MemWrite both high: the write occurs at the edge, and ReadData shows the pre-write value.
- Reset: every register clears to 0 on the first edge with reset = 1 (PORT_OUT, sync stages, STATUS, TMR_CNT, TMR_CMP, CTRL). Consequently PortOut = 0 and irq = 0. reset takes priority over a write in the same cycle.
- Input synchronizer:
  - Each edge: s1 <= PortIn; s2 <= s1; prev <= s2.
  - PORT_IN reads {zeros, s2}, so a PortIn change is readable after 2 edges.
  - in_changed sets on the edge where s2 != prev, i.e. the 3rd edge after the change.
  - Reset loads s1, s2 and prev with 0, so PortIn = 0xFF at reset release sets in_changed after 3 edges.
- STATUS W1C:
  - A written 1 clears the corresponding bit; a written 0 has no effect.
  - Set and clear in the same cycle: set wins, and the bit stays 1.
- Timer, evaluated each edge in priority order:
  1. Write to TMR_CNT: cnt <= WriteData.
  2. Else if tmr_en & auto_clr & (cnt == cmp): cnt <= 0.
  3. Else if tmr_en: cnt <= cnt + 1, modulo 2^32 (0xFFFF_FFFF wraps to 0).
- tmr_match sets on any edge where tmr_en & (cnt == cmp), using pre-edge values. It does not set while tmr_en = 0.
- With auto_clr: period = cmp + 1 cycles, and tmr_match re-sets every period.
- irq = (STATUS[0] & CTRL[2]) | (STATUS[1] & CTRL[3]).

Test Plan:
- Reset, then read offsets 0–5 -> all 0, PortOut = 0, irq = 0; read at BASE_ADDR+0x20 -> hit = 0, ReadData = 0.
- Store 0xDEADBEEF to BASE_ADDR+0 -> PortOut = 0xDEADBEEF the next cycle; load of the same address -> 0xDEADBEEF; load at +0x18 -> hit = 1, ReadData = 0.
- PortIn 0x00 -> 0x5A at cycle t -> PORT_IN reads 0x5A from t+2, STATUS = 1 from t+3; with CTRL = 0x4, irq = 1; write STATUS = 1 -> STATUS = 0 and irq = 0.
- TMR_CMP = 3, CTRL = 0x3 -> cnt sequence 0,1,2,3,0,1…; tmr_match sets on the edge leaving cnt = 3. Write-clear issued on the same edge as a match -> bit stays 1.
- TMR_CNT = 0xFFFF_FFFE, CTRL = 0x1, TMR_CMP = 5 -> cnt goes 0xFFFF_FFFF, 0, 1; no match until cnt = 5.
- Timer running at cnt = 7, reset asserted for 1 cycle -> next edge: cnt = 0, CTRL = 0, PortOut = 0, and the timer stays stopped.

Source files
------------

// File: rtl/mmio_port_responder.sv
// Memory-mapped responder beside the data RAM: output port, synchronized input
// port with change detection, and a 32-bit timer with compare match and irq.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0400,
  parameter int unsigned IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  output logic [31:0]         ReadData,
  output logic                hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                irq
);

  localparam logic [2:0] OFF_PORT_OUT = 3'd0;
  localparam logic [2:0] OFF_PORT_IN  = 3'd1;
  localparam logic [2:0] OFF_STATUS   = 3'd2;
  localparam logic [2:0] OFF_TMR_CNT  = 3'd3;
  localparam logic [2:0] OFF_TMR_CMP  = 3'd4;
  localparam logic [2:0] OFF_CTRL     = 3'd5;

  logic [31:0]         portOut_q, portOut_d;
  logic [IN_WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [1:0]          status_q, status_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [31:0]         cmp_q, cmp_d;
  logic [3:0]          ctrl_q, ctrl_d;

  logic [2:0]  offset;
  logic        wrEn;
  logic        tmrMatch;
  logic        inChanged;
  logic [31:0] portInWord;
  logic [31:0] readMux;
  logic [1:0]  unusedAddr;

  assign hit        = (MemRead | MemWrite) & (Address[31:5] == BASE_ADDR[31:5]);
  assign offset     = Address[4:2];
  assign unusedAddr = Address[1:0];
  assign wrEn       = MemWrite & hit;
  assign tmrMatch   = ctrl_q[0] & (cnt_q == cmp_q);
  assign inChanged  = (sync2_q != prev_q);
  assign portInWord = 32'(sync2_q);

  always_comb begin
    portOut_d = portOut_q;
    status_d  = status_q;
    cmp_d     = cmp_q;
    ctrl_d    = ctrl_q;
    if (wrEn) begin
      case (offset)
        OFF_PORT_OUT: portOut_d = WriteData;
        OFF_STATUS:   status_d  = status_q & ~WriteData[1:0];
        OFF_TMR_CMP:  cmp_d     = WriteData;
        OFF_CTRL:     ctrl_d    = WriteData[3:0];
        default:      ;
      endcase
    end
    // Hardware set events override a simultaneous write-one-to-clear.
    status_d = status_d | {tmrMatch, inChanged};

    cnt_d = cnt_q;
    if (wrEn && (offset == OFF_TMR_CNT)) begin
      cnt_d = WriteData;
    end else if (tmrMatch && ctrl_q[1]) begin
      cnt_d = '0;
    end else if (ctrl_q[0]) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      portOut_q <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      status_q  <= '0;
      cnt_q     <= '0;
      cmp_q     <= '0;
      ctrl_q    <= '0;
    end else begin
      portOut_q <= portOut_d;
      sync1_q   <= PortIn;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Reads are zero-latency so the MEM stage can mux them against RAM data.
  always_comb begin
    case (offset)
      OFF_PORT_OUT: readMux = portOut_q;
      OFF_PORT_IN:  readMux = portInWord;
      OFF_STATUS:   readMux = {30'b0, status_q};
      OFF_TMR_CNT:  readMux = cnt_q;
      OFF_TMR_CMP:  readMux = cmp_q;
      OFF_CTRL:     readMux = {28'b0, ctrl_q};
      default:      readMux = 32'h0;
    endcase
  end

  assign ReadData = (MemRead & hit) ? readMux : 32'h0;
  assign PortOut  = portOut_q;
  assign irq      = (status_q[0] & ctrl_q[2]) | (status_q[1] & ctrl_q[3]);

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: directed vector table, timer/reset sequences,
// and randomized traffic compared against a register-map reference model.
module tb_mmio_port_responder;

  localparam logic [31:0] B = 32'h1001_0400;

  logic        clk;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData;
  logic [31:0] ReadData;
  logic        hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        irq;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] sRd, sPo;
  logic        sHit, sIrq;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  pin;
    logic [31:0] expRd;
    logic        expHit;
    logic [31:0] expPo;
    logic        expIrq;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  mmio_port_responder #(.BASE_ADDR(B), .IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .hit(hit),
    .PortIn(PortIn), .PortOut(PortOut), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One bus cycle: drive, sample outputs before the edge, then pass the edge.
  task automatic applyStimulus(input logic rst, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [7:0] pin);
    reset = rst; MemRead = rd; MemWrite = wr;
    Address = addr; WriteData = wdata; PortIn = pin;
    @(negedge clk);
    sRd = ReadData; sHit = hit; sPo = PortOut; sIrq = irq;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic addVec(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [7:0] pin,
                        input logic [31:0] expRd, input logic expHit,
                        input logic [31:0] expPo, input logic expIrq, input string nm);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.pin = pin;
    v.expRd = expRd; v.expHit = expHit; v.expPo = expPo; v.expIrq = expIrq; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic rdChk(input int off, input logic [7:0] pin, input logic [31:0] exp,
                       input string nm);
    applyStimulus(1'b0, 1'b1, 1'b0, B + 32'(off * 4), 32'h0, pin);
    checkOutput(nm, sRd, exp);
  endtask

  task automatic wrReg(input int off, input logic [31:0] data, input logic [7:0] pin);
    applyStimulus(1'b0, 1'b0, 1'b1, B + 32'(off * 4), data, pin);
  endtask

  // Reference model state: registers as the programmer sees them.
  logic [31:0] mPo, mCnt, mCmp;
  logic [1:0]  mSt;
  logic [3:0]  mCtrl;
  logic [7:0]  mHist[3];

  function automatic logic [31:0] mRead(input logic [2:0] off);
    case (off)
      3'd0:    return mPo;
      3'd1:    return {24'b0, mHist[1]};
      3'd2:    return {30'b0, mSt};
      3'd3:    return mCnt;
      3'd4:    return mCmp;
      3'd5:    return {28'b0, mCtrl};
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    logic        rst, rd, wr, hitE, wrHit, matchNow, changedNow;
    logic [31:0] addr, wdata, expRd;
    logic [7:0]  pin;
    logic [2:0]  off, woff;
    logic [31:0] db;

    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    Address = '0; WriteData = '0; PortIn = '0;
    db = 32'hDEAD_BEEF;

    addVec(1, 0, B + 32'h00, 0, 0,          0, 1, 0, 0, "rst_out");
    addVec(1, 0, B + 32'h04, 0, 0,          0, 1, 0, 0, "rst_in");
    addVec(1, 0, B + 32'h08, 0, 0,          0, 1, 0, 0, "rst_stat");
    addVec(1, 0, B + 32'h0C, 0, 0,          0, 1, 0, 0, "rst_cnt");
    addVec(1, 0, B + 32'h10, 0, 0,          0, 1, 0, 0, "rst_cmp");
    addVec(1, 0, B + 32'h14, 0, 0,          0, 1, 0, 0, "rst_ctrl");
    addVec(1, 0, B + 32'h20, 0, 0,          0, 0, 0, 0, "miss");
    addVec(0, 1, B + 32'h00, db, 0,         0, 1, 0, 0, "wr_out");
    addVec(1, 0, B + 32'h00, 0, 0,         db, 1, db, 0, "rd_out");
    addVec(1, 0, B + 32'h18, 0, 0,          0, 1, db, 0, "rd_off6");
    addVec(0, 1, B + 32'h18, 32'h1234, 0,   0, 1, db, 0, "wr_off6");
    addVec(1, 0, B + 32'h1C, 0, 0,          0, 1, db, 0, "rd_off7");
    addVec(0, 1, B + 32'h04, 32'hFF, 0,     0, 1, db, 0, "wr_ro");
    addVec(1, 0, B + 32'h07, 0, 0,          0, 1, db, 0, "rd_in");
    addVec(1, 1, B + 32'h00, 32'h1, 0,     db, 1, db, 0, "rdwr_out");
    addVec(1, 0, B + 32'h00, 0, 0,          1, 1, 1, 0, "rd_out2");
    addVec(0, 0, B + 32'h00, 0, 0,          0, 0, 1, 0, "idle");
    addVec(0, 1, B + 32'h14, 32'hFFFF_FFF4, 0, 0, 1, 1, 0, "wr_ctrl");
    addVec(1, 0, B + 32'h14, 0, 0,          4, 1, 1, 0, "rd_ctrl");
    addVec(1, 0, B + 32'h04, 0, 8'h5A,      0, 1, 1, 0, "in_t0");
    addVec(1, 0, B + 32'h04, 0, 8'h5A,      0, 1, 1, 0, "in_t1");
    addVec(1, 0, B + 32'h04, 0, 8'h5A,  32'h5A, 1, 1, 0, "in_t2");
    addVec(1, 0, B + 32'h08, 0, 8'h5A,      1, 1, 1, 1, "stat_t3");
    addVec(0, 1, B + 32'h08, 32'h1, 8'h5A,  0, 1, 1, 1, "w1c");
    addVec(1, 0, B + 32'h08, 0, 8'h5A,      0, 1, 1, 0, "stat_clr");

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);

    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].pin);
      checkOutput({vecs[i].nm, "_rd"}, sRd, vecs[i].expRd);
      checkOutput({vecs[i].nm, "_hit"}, 32'(sHit), 32'(vecs[i].expHit));
      checkOutput({vecs[i].nm, "_po"}, sPo, vecs[i].expPo);
      checkOutput({vecs[i].nm, "_irq"}, 32'(sIrq), 32'(vecs[i].expIrq));
    end

    // Auto-clear timer with period cmp+1 and match racing a W1C clear.
    wrReg(4, 32'd3, 8'h5A);
    wrReg(5, 32'h3, 8'h5A);
    rdChk(3, 8'h5A, 32'd0, "ac_cnt0");
    rdChk(3, 8'h5A, 32'd1, "ac_cnt1");
    rdChk(3, 8'h5A, 32'd2, "ac_cnt2");
    rdChk(3, 8'h5A, 32'd3, "ac_cnt3");
    rdChk(2, 8'h5A, 32'd2, "ac_match");
    wrReg(2, 32'h2, 8'h5A);
    rdChk(2, 8'h5A, 32'd0, "ac_cleared");
    wrReg(2, 32'h2, 8'h5A);
    rdChk(2, 8'h5A, 32'd2, "ac_set_wins");

    // Free-running wrap through 0xFFFF_FFFF with a compare far away.
    wrReg(5, 32'h0, 8'h5A);
    wrReg(2, 32'h3, 8'h5A);
    wrReg(4, 32'd5, 8'h5A);
    wrReg(3, 32'hFFFF_FFFE, 8'h5A);
    wrReg(5, 32'h1, 8'h5A);
    rdChk(3, 8'h5A, 32'hFFFF_FFFE, "wr_cnt_fe");
    rdChk(3, 8'h5A, 32'hFFFF_FFFF, "wr_cnt_ff");
    rdChk(3, 8'h5A, 32'h0, "wr_cnt_wrap");
    rdChk(3, 8'h5A, 32'h1, "wr_cnt_1");
    rdChk(2, 8'h5A, 32'h0, "wr_nomatch");
    rdChk(3, 8'h5A, 32'd3, "wr_cnt_3");
    rdChk(3, 8'h5A, 32'd4, "wr_cnt_4");
    rdChk(3, 8'h5A, 32'd5, "wr_cnt_5");
    rdChk(2, 8'h5A, 32'h2, "wr_match");

    // One-cycle reset while the timer sits at 7, PortIn held high across release.
    applyStimulus(1'b1, 1'b1, 1'b0, B + 32'h0C, 32'h0, 8'hFF);
    checkOutput("rs_cnt7", sRd, 32'd7);
    rdChk(3, 8'hFF, 32'd0, "rs_cnt");
    checkOutput("rs_po", sPo, 32'h0);
    rdChk(5, 8'hFF, 32'd0, "rs_ctrl");
    rdChk(2, 8'hFF, 32'd0, "rs_stat_pre");
    rdChk(2, 8'hFF, 32'd1, "rs_in_changed");
    rdChk(3, 8'hFF, 32'd0, "rs_stopped");
    applyStimulus(1'b1, 1'b0, 1'b1, B, 32'hAAAA, 8'hFF);
    rdChk(0, 8'hFF, 32'd0, "rs_over_wr");

    // Randomized traffic against the reference model.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
    mPo = '0; mCnt = '0; mCmp = '0; mSt = '0; mCtrl = '0;
    mHist[0] = '0; mHist[1] = '0; mHist[2] = '0;
    pin = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      off = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) addr = $urandom;
      else addr = B | (32'(off) << 2) | 32'($urandom_range(0, 3));
      wdata = (addr[4:2] == 3'd3 || addr[4:2] == 3'd4) ? 32'($urandom_range(0, 12)) : $urandom;
      if ($urandom_range(0, 7) == 0) pin = 8'($urandom);

      hitE  = (rd | wr) && (addr[31:5] == B[31:5]);
      expRd = (rd && hitE) ? mRead(addr[4:2]) : 32'h0;
      applyStimulus(rst, rd, wr, addr, wdata, pin);
      checkOutput("rnd_rd", sRd, expRd);
      checkOutput("rnd_hit", 32'(sHit), 32'(hitE));
      checkOutput("rnd_po", sPo, mPo);
      checkOutput("rnd_irq", 32'(sIrq), 32'((mSt[0] & mCtrl[2]) | (mSt[1] & mCtrl[3])));

      if (rst) begin
        mPo = '0; mCnt = '0; mCmp = '0; mSt = '0; mCtrl = '0;
        mHist[0] = '0; mHist[1] = '0; mHist[2] = '0;
      end else begin
        wrHit      = wr && hitE;
        woff       = addr[4:2];
        matchNow   = mCtrl[0] && (mCnt == mCmp);
        changedNow = (mHist[1] != mHist[2]);
        if (wrHit && woff == 3'd2) mSt = mSt & ~wdata[1:0];
        if (matchNow) mSt[1] = 1'b1;
        if (changedNow) mSt[0] = 1'b1;
        if (wrHit && woff == 3'd3) mCnt = wdata;
        else if (matchNow && mCtrl[1]) mCnt = 32'h0;
        else if (mCtrl[0]) mCnt = mCnt + 32'd1;
        if (wrHit && woff == 3'd0) mPo = wdata;
        if (wrHit && woff == 3'd4) mCmp = wdata;
        if (wrHit && woff == 3'd5) mCtrl = wdata[3:0];
        mHist[2] = mHist[1];
        mHist[1] = mHist[0];
        mHist[0] = pin;
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
